// File: rtl/hazard_ctrl.sv
// Hazard controller for the 5-stage core: load-use interlock, multdiv
// sequencing with a latency watchdog, taken-branch flush and stall counting.
module hazard_ctrl #(
  parameter int MD_TIMEOUT = 40,
  parameter int CNT_W      = 6
) (
  input  logic        clock,
  input  logic        reset,
  input  logic [4:0]  fd_rs1,
  input  logic [4:0]  fd_rs2,
  input  logic        fd_uses_rs1,
  input  logic        fd_uses_rs2,
  input  logic [4:0]  dx_rd,
  input  logic        dx_is_load,
  input  logic        dx_is_mult,
  input  logic        dx_is_div,
  input  logic        br_taken,
  input  logic        md_ready,
  input  logic        md_exception,
  output logic        stall_pc,
  output logic        stall_fd,
  output logic        stall_dx,
  output logic        bubble_dx,
  output logic        bubble_xm,
  output logic        flush_fd,
  output logic        md_start_mult,
  output logic        md_start_div,
  output logic        md_result_sel,
  output logic        md_exc,
  output logic        md_busy,
  output logic [31:0] stall_count
);

  localparam logic [0:0] IDLE = 1'b0;
  localparam logic [0:0] BUSY = 1'b1;

  localparam logic [CNT_W-1:0] WDOG_LAST = CNT_W'(MD_TIMEOUT - 1);

  logic [0:0]       state;
  logic [0:0]       state_next;
  logic [CNT_W-1:0] wdog;
  logic [CNT_W-1:0] wdog_next;
  logic [31:0]      stall_cnt;

  logic md_req;
  logic src_hit;
  logic load_use;
  logic wdog_expired;

  assign md_req       = dx_is_mult | dx_is_div;
  assign src_hit      = (fd_uses_rs1 && (fd_rs1 == dx_rd)) ||
                        (fd_uses_rs2 && (fd_rs2 == dx_rd));
  assign load_use     = dx_is_load && (dx_rd != 5'd0) && src_hit;
  assign wdog_expired = (wdog == WDOG_LAST);

  // Priority: multdiv stall, then branch flush, then load-use. Everything is
  // forced quiet while reset is held, independent of the pipeline inputs.
  always_comb begin
    state_next    = state;
    wdog_next     = wdog;
    stall_pc      = 1'b0;
    stall_fd      = 1'b0;
    stall_dx      = 1'b0;
    bubble_dx     = 1'b0;
    bubble_xm     = 1'b0;
    flush_fd      = 1'b0;
    md_start_mult = 1'b0;
    md_start_div  = 1'b0;
    md_result_sel = 1'b0;
    md_exc        = 1'b0;

    if (reset) begin
      case (state)
        IDLE: begin
          if (md_req) begin
            md_start_mult = dx_is_mult;
            md_start_div  = dx_is_div & ~dx_is_mult;
            stall_pc      = 1'b1;
            stall_fd      = 1'b1;
            stall_dx      = 1'b1;
            bubble_xm     = 1'b1;
            wdog_next     = '0;
            state_next    = BUSY;
          end else if (br_taken) begin
            flush_fd  = 1'b1;
            bubble_dx = 1'b1;
          end else if (load_use) begin
            stall_pc  = 1'b1;
            stall_fd  = 1'b1;
            bubble_dx = 1'b1;
          end
        end

        BUSY: begin
          // A missing md_ready is reported as an error once the watchdog runs out.
          if (md_ready || wdog_expired) begin
            md_result_sel = 1'b1;
            md_exc        = md_ready ? md_exception : 1'b1;
            wdog_next     = '0;
            state_next    = IDLE;
          end else begin
            stall_pc  = 1'b1;
            stall_fd  = 1'b1;
            stall_dx  = 1'b1;
            bubble_xm = 1'b1;
            wdog_next = wdog + CNT_W'(1);
          end
        end

        default: begin
          state_next = IDLE;
          wdog_next  = '0;
        end
      endcase
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state <= IDLE;
      wdog  <= '0;
    end else begin
      state <= state_next;
      wdog  <= wdog_next;
    end
  end

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      stall_cnt <= 32'd0;
    end else if (stall_pc) begin
      stall_cnt <= stall_cnt + 32'd1;
    end
  end

  assign md_busy     = (state == BUSY);
  assign stall_count = stall_cnt;

endmodule

// File: tb/tb_hazard_ctrl.sv
// Directed bench for hazard_ctrl: a cycle-level behavioural model checked every
// cycle, plus hand-computed expectations for the key scenarios.
module tb_hazard_ctrl;

  localparam int MD_TIMEOUT = 40;

  logic        clock = 1'b0;
  logic        reset;
  logic [4:0]  fd_rs1, fd_rs2, dx_rd;
  logic        fd_uses_rs1, fd_uses_rs2;
  logic        dx_is_load, dx_is_mult, dx_is_div;
  logic        br_taken, md_ready, md_exception;
  logic        stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
  logic        md_start_mult, md_start_div, md_result_sel, md_exc, md_busy;
  logic [31:0] stall_count;

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT), .CNT_W(6)) dut (
    .clock(clock), .reset(reset),
    .fd_rs1(fd_rs1), .fd_rs2(fd_rs2),
    .fd_uses_rs1(fd_uses_rs1), .fd_uses_rs2(fd_uses_rs2),
    .dx_rd(dx_rd), .dx_is_load(dx_is_load),
    .dx_is_mult(dx_is_mult), .dx_is_div(dx_is_div),
    .br_taken(br_taken), .md_ready(md_ready), .md_exception(md_exception),
    .stall_pc(stall_pc), .stall_fd(stall_fd), .stall_dx(stall_dx),
    .bubble_dx(bubble_dx), .bubble_xm(bubble_xm), .flush_fd(flush_fd),
    .md_start_mult(md_start_mult), .md_start_div(md_start_div),
    .md_result_sel(md_result_sel), .md_exc(md_exc), .md_busy(md_busy),
    .stall_count(stall_count)
  );

  always #5 clock = ~clock;

  typedef struct packed {
    logic stall_pc, stall_fd, stall_dx, bubble_dx, bubble_xm, flush_fd;
    logic start_mult, start_div, result_sel, exc;
  } ctl_t;

  // Model state: whether a multdiv op is outstanding and on which cycle it was issued.
  bit          m_busy = 1'b0;
  int          m_issue = 0;
  int          cyc = 0;
  logic [31:0] m_stalls = 32'd0;
  ctl_t        exp_now;

  function automatic ctl_t model_ctl();
    ctl_t c = '0;
    bit hazard;
    hazard = dx_is_load && (dx_rd != 5'd0) &&
             ((fd_uses_rs1 && fd_rs1 == dx_rd) || (fd_uses_rs2 && fd_rs2 == dx_rd));
    if (reset !== 1'b1) return c;
    if (m_busy) begin
      if (md_ready || (cyc - m_issue) >= MD_TIMEOUT) begin
        c.result_sel = 1'b1;
        c.exc        = md_ready ? md_exception : 1'b1;
      end else begin
        {c.stall_pc, c.stall_fd, c.stall_dx, c.bubble_xm} = 4'b1111;
      end
    end else if (dx_is_mult || dx_is_div) begin
      {c.stall_pc, c.stall_fd, c.stall_dx, c.bubble_xm} = 4'b1111;
      c.start_mult = dx_is_mult;
      c.start_div  = dx_is_div && !dx_is_mult;
    end else if (br_taken) begin
      c.flush_fd  = 1'b1;
      c.bubble_dx = 1'b1;
    end else if (hazard) begin
      c.stall_pc  = 1'b1;
      c.stall_fd  = 1'b1;
      c.bubble_dx = 1'b1;
    end
    return c;
  endfunction

  always_comb exp_now = model_ctl();

  always @(posedge clock) begin
    if (reset !== 1'b1) begin
      m_busy   <= 1'b0;
      m_stalls <= 32'd0;
    end else begin
      if (exp_now.stall_pc) m_stalls <= m_stalls + 32'd1;
      if (!m_busy && (dx_is_mult || dx_is_div)) begin
        m_busy  <= 1'b1;
        m_issue <= cyc;
      end else if (m_busy && exp_now.result_sel) begin
        m_busy <= 1'b0;
      end
    end
    cyc <= cyc + 1;
  end

  task automatic check_output(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic check_all();
    check_output("m_stall_pc",   stall_pc,      exp_now.stall_pc);
    check_output("m_stall_fd",   stall_fd,      exp_now.stall_fd);
    check_output("m_stall_dx",   stall_dx,      exp_now.stall_dx);
    check_output("m_bubble_dx",  bubble_dx,     exp_now.bubble_dx);
    check_output("m_bubble_xm",  bubble_xm,     exp_now.bubble_xm);
    check_output("m_flush_fd",   flush_fd,      exp_now.flush_fd);
    check_output("m_start_mult", md_start_mult, exp_now.start_mult);
    check_output("m_start_div",  md_start_div,  exp_now.start_div);
    check_output("m_result_sel", md_result_sel, exp_now.result_sel);
    check_output("m_md_exc",     md_exc,        exp_now.exc);
    check_output("m_md_busy",    md_busy,       (reset === 1'b1) ? m_busy : 1'b0);
    check_output("m_stall_count", stall_count,  (reset === 1'b1) ? m_stalls : 32'd0);
  endtask

  always @(negedge clock) check_all();

  task automatic next_cycle();
    @(posedge clock);
    #1;
  endtask

  task automatic apply_stimulus(input logic [4:0] rs1, input logic [4:0] rs2,
                                input logic u1, input logic u2, input logic [4:0] rd,
                                input logic ld, input logic br);
    fd_rs1 = rs1; fd_rs2 = rs2; fd_uses_rs1 = u1; fd_uses_rs2 = u2;
    dx_rd = rd; dx_is_load = ld; br_taken = br;
  endtask

  task automatic clear_inputs();
    apply_stimulus(5'd0, 5'd0, 1'b0, 1'b0, 5'd0, 1'b0, 1'b0);
    dx_is_mult = 1'b0; dx_is_div = 1'b0; md_ready = 1'b0; md_exception = 1'b0;
  endtask

  typedef struct {
    logic [4:0] rs1, rs2, rd;
    logic u1, u2, ld, br;
    logic e_stall, e_bub, e_flush;
  } lu_vec_t;

  lu_vec_t lu_vecs[8];

  initial begin
    lu_vecs[0] = '{5'd5,  5'd3,  5'd3,  1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    lu_vecs[1] = '{5'd0,  5'd0,  5'd0,  1'b1, 1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    lu_vecs[2] = '{5'd4,  5'd3,  5'd3,  1'b1, 1'b0, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0};
    lu_vecs[3] = '{5'd7,  5'd1,  5'd7,  1'b1, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};
    lu_vecs[4] = '{5'd5,  5'd3,  5'd3,  1'b1, 1'b1, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1};
    lu_vecs[5] = '{5'd3,  5'd2,  5'd3,  1'b1, 1'b1, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0};
    lu_vecs[6] = '{5'd1,  5'd2,  5'd9,  1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b1, 1'b1};
    lu_vecs[7] = '{5'd8,  5'd31, 5'd31, 1'b0, 1'b1, 1'b1, 1'b0, 1'b1, 1'b1, 1'b0};

    // Reset held with hazard-provoking inputs: everything stays quiet.
    reset = 1'b0;
    clear_inputs();
    dx_is_mult = 1'b1;
    apply_stimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    repeat (3) @(negedge clock);
    check_output("rst_stall_pc", stall_pc, 1'b0);
    check_output("rst_start_mult", md_start_mult, 1'b0);
    check_output("rst_flush_fd", flush_fd, 1'b0);
    check_output("rst_md_busy", md_busy, 1'b0);
    next_cycle();
    clear_inputs();
    reset = 1'b1;
    next_cycle();
    @(negedge clock);
    check_output("rst_stall_count", stall_count, 32'd0);

    // mul: issue at T, md_ready at T+17 -> 17 stall cycles.
    next_cycle();
    dx_is_mult = 1'b1;
    @(negedge clock);
    check_output("mul_start_T", md_start_mult, 1'b1);
    check_output("mul_stall_T", stall_pc, 1'b1);
    check_output("mul_busy_T", md_busy, 1'b0);
    next_cycle();
    @(negedge clock);
    check_output("mul_start_T1", md_start_mult, 1'b0);
    check_output("mul_busy_T1", md_busy, 1'b1);
    for (int i = 2; i < 17; i++) next_cycle();
    @(negedge clock);
    check_output("mul_stall_R1", stall_dx, 1'b1);
    next_cycle();
    md_ready = 1'b1;
    @(negedge clock);
    check_output("mul_sel_R", md_result_sel, 1'b1);
    check_output("mul_stall_R", stall_pc, 1'b0);
    check_output("mul_start_R", md_start_mult, 1'b0);
    check_output("mul_busy_R", md_busy, 1'b1);
    next_cycle();
    dx_is_mult = 1'b0;
    md_ready = 1'b0;
    @(negedge clock);
    check_output("mul_busy_R1", md_busy, 1'b0);
    check_output("mul_stall_count", stall_count, 32'd17);

    // div with no md_ready: watchdog forces completion at T+MD_TIMEOUT.
    next_cycle();
    dx_is_div = 1'b1;
    @(negedge clock);
    check_output("div_start_div", md_start_div, 1'b1);
    check_output("div_start_mult", md_start_mult, 1'b0);
    for (int i = 1; i < MD_TIMEOUT; i++) next_cycle();
    @(negedge clock);
    check_output("div_stall_last", stall_pc, 1'b1);
    check_output("div_exc_early", md_exc, 1'b0);
    next_cycle();
    @(negedge clock);
    check_output("div_timeout_sel", md_result_sel, 1'b1);
    check_output("div_timeout_exc", md_exc, 1'b1);
    check_output("div_timeout_stall", stall_pc, 1'b0);
    check_output("div_no_restart", md_start_div, 1'b0);
    next_cycle();
    dx_is_div = 1'b0;
    @(negedge clock);
    check_output("div_busy_after", md_busy, 1'b0);
    check_output("div_stall_count", stall_count, 32'd57);

    // Load-use / branch vectors, each followed by a quiet cycle.
    foreach (lu_vecs[k]) begin
      next_cycle();
      apply_stimulus(lu_vecs[k].rs1, lu_vecs[k].rs2, lu_vecs[k].u1, lu_vecs[k].u2,
                     lu_vecs[k].rd, lu_vecs[k].ld, lu_vecs[k].br);
      @(negedge clock);
      check_output($sformatf("lu%0d_stall_pc", k), stall_pc, lu_vecs[k].e_stall);
      check_output($sformatf("lu%0d_stall_fd", k), stall_fd, lu_vecs[k].e_stall);
      check_output($sformatf("lu%0d_bubble_dx", k), bubble_dx, lu_vecs[k].e_bub);
      check_output($sformatf("lu%0d_flush_fd", k), flush_fd, lu_vecs[k].e_flush);
      check_output($sformatf("lu%0d_stall_dx", k), stall_dx, 1'b0);
      next_cycle();
      clear_inputs();
    end
    @(negedge clock);
    check_output("lu_stall_count", stall_count, 32'd60);

    // Back-to-back mul: starts at T and R+1 only.
    next_cycle();
    dx_is_mult = 1'b1;
    @(negedge clock);
    check_output("b2b_start_T", md_start_mult, 1'b1);
    repeat (3) next_cycle();
    next_cycle();
    md_ready = 1'b1;
    @(negedge clock);
    check_output("b2b_start_R", md_start_mult, 1'b0);
    check_output("b2b_sel_R", md_result_sel, 1'b1);
    next_cycle();
    md_ready = 1'b0;
    @(negedge clock);
    check_output("b2b_start_R1", md_start_mult, 1'b1);
    check_output("b2b_busy_R1", md_busy, 1'b0);
    next_cycle();
    apply_stimulus(5'd3, 5'd0, 1'b1, 1'b0, 5'd3, 1'b1, 1'b1);
    @(negedge clock);
    check_output("b2b_busy_flush", flush_fd, 1'b0);
    check_output("b2b_busy_bubble_dx", bubble_dx, 1'b0);
    check_output("b2b_busy_stall", stall_pc, 1'b1);
    next_cycle();
    md_ready = 1'b1;
    md_exception = 1'b1;
    @(negedge clock);
    check_output("b2b_exc", md_exc, 1'b1);
    check_output("b2b_sel2", md_result_sel, 1'b1);
    next_cycle();
    clear_inputs();
    @(negedge clock);
    check_output("b2b_idle", md_busy, 1'b0);

    // Reset mid-BUSY, then a stale md_ready in IDLE.
    next_cycle();
    dx_is_div = 1'b1;
    repeat (3) next_cycle();
    #2 reset = 1'b0;
    #1;
    check_output("mid_rst_stall_pc", stall_pc, 1'b0);
    check_output("mid_rst_bubble_xm", bubble_xm, 1'b0);
    check_output("mid_rst_busy", md_busy, 1'b0);
    check_output("mid_rst_count", stall_count, 32'd0);
    next_cycle();
    md_ready = 1'b1;
    next_cycle();
    reset = 1'b1;
    dx_is_div = 1'b0;
    @(negedge clock);
    check_output("stale_ready_sel", md_result_sel, 1'b0);
    check_output("stale_ready_exc", md_exc, 1'b0);
    next_cycle();
    md_ready = 1'b0;
    @(negedge clock);
    check_output("stale_ready_busy", md_busy, 1'b0);
    check_output("stale_ready_count", stall_count, 32'd0);

    next_cycle();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #200000;
    $display("[TB] FAIL global_timeout: simulation did not complete");
    $fatal(1, "[TB] timeout");
  end

endmodule
